// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Brief  : Shared constants, line type and backing-store helper for the
//          direct-mapped cache.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } line_t;

  // Synthetic backing store: each word holds its own word-aligned address.
  function automatic logic [DATA_W-1:0] backing_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_cache_line_store.sv
// ============================================================================
// Module : dm_cache_line_store
// Brief  : Valid/tag/data arrays; valid bits cleared asynchronously, one
//          combinational read port and one fill write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_cache_line_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output line_t              rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_tag[wr_index]  <= wr_tag;
      r_data[wr_index] <= wr_data;
    end
  end

  assign rd_line.valid = r_valid[rd_index];
  assign rd_line.tag   = r_tag[rd_index];
  assign rd_line.data  = r_data[rd_index];

endmodule

`default_nettype wire

// File: rtl/direct_mapped_cache.sv
// ============================================================================
// Module : direct_mapped_cache
// Brief  : Read-only direct-mapped cache, one lookup per cycle, refill on miss,
//          saturating hit counter. CACHE_ACCESS_COUNT_EN adds access_count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module direct_mapped_cache
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Hit_Miss,
  output logic [31:0]       rate
`ifdef CACHE_ACCESS_COUNT_EN
  ,
  output logic [31:0]       access_count
`endif
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [DATA_W-1:0]  w_backing;
  logic               w_hit;
  line_t              w_line;
  logic               w_unused_offset;

  assign w_index         = Address[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag           = Address[ADDR_W-1:OFFSET_W+INDEX_W];
  assign w_backing       = backing_word(Address);
  assign w_unused_offset = ^Address[OFFSET_W-1:0];

  dm_cache_line_store u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (w_index),
    .rd_line  (w_line),
    .wr_en    (!w_hit),
    .wr_index (w_index),
    .wr_tag   (w_tag),
    .wr_data  (w_backing)
  );

  assign w_hit = w_line.valid && (w_line.tag == w_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Data_Out <= '0;
      Hit_Miss <= 1'b0;
      rate     <= '0;
    end else begin
      Hit_Miss <= w_hit;
      Data_Out <= w_hit ? w_line.data : w_backing;
      if (w_hit && rate != CNT_MAX) begin
        rate <= rate + 32'd1;
      end
    end
  end

`ifdef CACHE_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
    end else if (access_count != CNT_MAX) begin
      access_count <= access_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_direct_mapped_cache.sv
// ============================================================================
// Module : tb_direct_mapped_cache
// Brief  : Self-checking bench for direct_mapped_cache with a reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_direct_mapped_cache;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] Data_Out;
  logic        Hit_Miss;
  logic [31:0] rate;
`ifdef CACHE_ACCESS_COUNT_EN
  logic [31:0] access_count;
`endif

  int n_checks;
  int n_fail;

  // Reference model: per-line valid/tag plus counters.
  bit          m_valid [256];
  int unsigned m_tag   [256];
  int unsigned m_rate;
  int unsigned m_access;

  direct_mapped_cache dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Address  (Address),
    .Data_Out (Data_Out),
    .Hit_Miss (Hit_Miss),
    .rate     (rate)
`ifdef CACHE_ACCESS_COUNT_EN
    ,
    .access_count (access_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_rate   = 0;
    m_access = 0;
  endtask

  // Present addr, clock once, compare outputs against the model.
  task automatic do_lookup(input logic [31:0] addr);
    int unsigned idx;
    int unsigned tg;
    bit          hit;
    idx = (addr / 4) % 256;
    tg  = addr / 1024;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end else if (m_rate != 32'hFFFF_FFFF) begin
      m_rate++;
    end
    if (m_access != 32'hFFFF_FFFF) m_access++;
    Address = addr;
    @(posedge clk);
    #1;
    check("hit_miss", {63'd0, Hit_Miss}, {63'd0, hit});
    check("data_out", {32'd0, Data_Out}, {32'd0, addr & ~32'h3});
    check("rate", {32'd0, rate}, {32'd0, m_rate});
`ifdef CACHE_ACCESS_COUNT_EN
    check("access_count", {32'd0, access_count}, {32'd0, m_access});
`endif
  endtask

  initial begin
    logic [31:0] a;
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    rst_n   = 1'b0;
    Address = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hit", {63'd0, Hit_Miss}, 64'd0);
    check("rst_data", {32'd0, Data_Out}, 64'd0);
    check("rst_rate", {32'd0, rate}, 64'd0);
    rst_n = 1'b1;

    // Directed sequence with literal expectations on top of the model.
    do_lookup(32'h0000_0010);
    check("first_miss", {63'd0, Hit_Miss}, 64'd0);
    do_lookup(32'h0000_0010);
    check("held_hit", {63'd0, Hit_Miss}, 64'd1);
    check("held_rate", {32'd0, rate}, 64'd1);
    do_lookup(32'h0000_0013);
    check("offset_data", {32'd0, Data_Out}, 64'h10);
    check("offset_rate", {32'd0, rate}, 64'd2);
    do_lookup(32'h0000_0410);
    check("conflict_miss", {63'd0, Hit_Miss}, 64'd0);
    do_lookup(32'h0000_0010);
    check("evicted_miss", {63'd0, Hit_Miss}, 64'd0);
    check("evicted_rate", {32'd0, rate}, 64'd2);
    do_lookup(32'h0000_0000);
    do_lookup(32'h0000_0004);
    do_lookup(32'h0000_0000);
    do_lookup(32'h0000_0004);
    check("distinct_rate", {32'd0, rate}, 64'd4);

    // Asynchronous reset mid-cycle.
    rst_n = 1'b0;
    #1;
    check("async_hit", {63'd0, Hit_Miss}, 64'd0);
    check("async_data", {32'd0, Data_Out}, 64'd0);
    check("async_rate", {32'd0, rate}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    do_lookup(32'h0000_0004);
    check("post_rst_miss", {63'd0, Hit_Miss}, 64'd0);

    // Randomised traffic concentrated on a few lines and tags to provoke
    // both hits and conflict evictions, with occasional wide tags.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0)
        a = $urandom();
      else
        a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      do_lookup(a);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
Read-only, direct-mapped, one-word-per-line cache model used in trace-driven hit-rate experiments. Each clock cycle it looks up the presented 32-bit byte address, reports hit/miss, returns the data word, and refills the line on a miss from an internal synthetic backing store. A running hit counter is exported for statistics.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits
INDEX_W, 8, line-index bits (2^INDEX_W = 256 lines)
OFFSET_W, 2, byte-offset bits within the word (ignored for lookup)

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
Address  in  ADDR_W  byte address looked up every cycle
Data_Out  out  DATA_W  data word for the last sampled address (registered)
Hit_Miss  out  1  1 = last lookup hit, 0 = miss (registered)
rate  out  32  number of hits since reset (registered)

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low. While low: all valid bits cleared, Data_Out=0, Hit_Miss=0, rate=0. Deassertion is synchronised by the integrator; first lookup occurs on the first rising edge with rst_n high.
- Address split: offset=Address[OFFSET_W-1:0] (ignored); index=Address[OFFSET_W+INDEX_W-1:OFFSET_W]; tag=Address[ADDR_W-1:OFFSET_W+INDEX_W] (22 bits by default).
- One lookup per rising edge, unconditionally (no request qualifier); 1-cycle latency: outputs reflect the Address sampled at that edge.
- Hit: valid[index]=1 and tag_mem[index]==tag -> Hit_Miss=1, Data_Out=data_mem[index], rate+=1.
- Miss: Hit_Miss=0; line filled on the same edge: valid[index]=1, tag_mem[index]=tag, data_mem[index]=backing word; Data_Out=backing word (no stall, no miss penalty cycles).
- Backing word = {Address[ADDR_W-1:OFFSET_W], OFFSET_W'b0} (word-aligned address); hits therefore return the same value as a miss would.
- Replacement: direct-mapped; a miss unconditionally evicts the resident line. No writes, no dirty state.
- rate saturates at 32'hFFFF_FFFF (no wrap).
- Holding Address constant: first cycle miss (if not resident), every following cycle hit; each counted.
- X on Address: undefined result; bench must drive known values.

Optional Feature:
Macro CACHE_ACCESS_COUNT_EN. Defined: adds output port access_count (32 bits, reset 0, increments every lookup edge, saturating), so hit ratio = rate/access_count can be computed externally. Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package cache_pkg: ADDR_W/DATA_W constants, default INDEX_W/OFFSET_W, derived TAG_W, a line struct typedef {valid, tag, data}, and a function computing the backing word from an address.
- One sub-module natural: dm_cache_line_store (valid/tag/data arrays with async clear of valid bits, one read port, one write port on fill); top holds address split, compare, output registers and counters.

Test Plan:
- Reset then Address=0x0000_0010 -> Hit_Miss=0, Data_Out=0x0000_0010, rate=0.
- Address 0x0000_0010 held a second cycle -> Hit_Miss=1, Data_Out=0x0000_0010, rate=1; then 0x0000_0013 -> hit (offset ignored), Data_Out=0x0000_0010, rate=2.
- Conflict: 0x0000_0410 (index 4, tag 1) -> miss, Data_Out=0x0000_0410; then 0x0000_0010 -> miss (evicted), rate unchanged.
- Distinct lines: 0x0000_0000, 0x0000_0004, 0x0000_0000, 0x0000_0004 -> miss, miss, hit, hit; rate +2.
- Reset mid-run: after the sequences above pull rst_n low -> outputs 0 immediately; after release 0x0000_0004 -> miss.
- With CACHE_ACCESS_COUNT_EN: 10 lookups after reset -> access_count=10; rate equals hits counted by the bench model.
